// File: rtl/ball_pkg.sv
// Shared types and key constants for the player-ball motion controller.
package ball_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    HANG   = 2'd2,
    FALL   = 2'd3
  } motion_phase_t;

  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  localparam int VEL_W = 10;

endpackage

// File: rtl/keycode_match.sv
// Reports whether a given HID key appears in any of the four keycode byte slots.
module keycode_match (
  input  logic [31:0] keycode,
  input  logic [7:0]  key,
  output logic        hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == key) hit = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_sequencer.sv
// Per-frame player-ball motion controller: key decode, jump-phase FSM, charge timer
// and registered signed X/Y velocity commands for the ball position datapath.
module ball_motion_sequencer
  import ball_pkg::*;
#(
  parameter int RISE_FRAMES   = 7,
  parameter int HANG_FRAMES   = 5,
  parameter int JUMP_VEL      = 8,
  parameter int FALL_MAX      = 3,
  parameter int MAX_JUMPS     = 2,
  parameter int RUN_SPEED     = 1,
  parameter int CHARGED_SPEED = 2,
  parameter int CHARGE_FRAMES = 240
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    run_en,
  input  logic [31:0]             keycode,
  input  logic                    in_air,
  input  logic                    touch_down,
  input  logic                    touch_up,
  input  logic                    touch_left,
  input  logic                    touch_right,
  input  logic                    charge_pulse,
  output logic signed [VEL_W-1:0] vx,
  output logic signed [VEL_W-1:0] vy,
  output logic [1:0]              phase,
  output logic [1:0]              jumps_used,
  output logic                    facing_left,
  output logic                    charged
);

  localparam int CNT_MAX = (RISE_FRAMES > HANG_FRAMES) ? RISE_FRAMES : HANG_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FALL_W  = $clog2(FALL_MAX + 1);
  localparam int CHG_W   = $clog2(CHARGE_FRAMES + 1);

  localparam logic [CNT_W-1:0]         RISE_LAST = CNT_W'(RISE_FRAMES - 1);
  localparam logic [CNT_W-1:0]         HANG_LAST = CNT_W'(HANG_FRAMES - 1);
  localparam logic [FALL_W-1:0]        FALL_TOP  = FALL_W'(FALL_MAX);
  localparam logic [CHG_W-1:0]         CHG_FULL  = CHG_W'(CHARGE_FRAMES);
  localparam logic [1:0]               JUMPS_TOP = 2'(MAX_JUMPS);
  localparam logic signed [VEL_W-1:0]  VY_RISE   = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0]  SPD_RUN   = VEL_W'(RUN_SPEED);
  localparam logic signed [VEL_W-1:0]  SPD_CHG   = VEL_W'(CHARGED_SPEED);

  motion_phase_t            state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [FALL_W-1:0]        fall_spd, fall_nxt;
  logic [1:0]               jumps_nxt;
  logic [CHG_W-1:0]         timer, timer_nxt;
  logic                     charged_nxt;
  logic                     jump_prev;
  logic                     hit_right, hit_left, jump_held, jump_press;
  logic signed [VEL_W-1:0]  spd, vx_nxt, vy_nxt;
  logic                     facing_nxt;

  function automatic logic [FALL_W-1:0] sat_inc_fall(input logic [FALL_W-1:0] v);
    return (v >= FALL_TOP) ? FALL_TOP : v + 1'b1;
  endfunction

  keycode_match u_match_right (.keycode(keycode), .key(KEY_RIGHT), .hit(hit_right));
  keycode_match u_match_left  (.keycode(keycode), .key(KEY_LEFT),  .hit(hit_left));
  keycode_match u_match_jump  (.keycode(keycode), .key(KEY_JUMP),  .hit(jump_held));

  assign jump_press = jump_held && !jump_prev;
  assign phase      = state;

  // Charge timer and horizontal velocity; speed follows the charge state it lands with
  always_comb begin
    timer_nxt = timer;
    if (charge_pulse)      timer_nxt = CHG_FULL;
    else if (timer != '0)  timer_nxt = timer - 1'b1;
    charged_nxt = (timer_nxt != '0);
    spd         = charged_nxt ? SPD_CHG : SPD_RUN;
    vx_nxt      = '0;
    facing_nxt  = facing_left;
    if (hit_right) begin
      facing_nxt = 1'b0;
      if (!touch_right) vx_nxt = spd;
    end else if (hit_left) begin
      facing_nxt = 1'b1;
      if (!touch_left) vx_nxt = -spd;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fall_nxt  = fall_spd;
    jumps_nxt = jumps_used;
    unique case (state)
      GROUND: begin
        jumps_nxt = 2'd0;
        if (jump_press) begin
          state_nxt = RISE;
          cnt_nxt   = '0;
          jumps_nxt = 2'd1;
        end else if (in_air) begin
          state_nxt = FALL;
          fall_nxt  = FALL_W'(1);
          jumps_nxt = 2'd1;
        end
      end
      RISE: begin
        if (touch_up) begin
          state_nxt = FALL;
          fall_nxt  = FALL_W'(1);
        end else if (!jump_held || cnt == RISE_LAST) begin
          state_nxt = HANG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HANG: begin
        if (cnt == HANG_LAST) begin
          state_nxt = FALL;
          fall_nxt  = FALL_W'(1);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FALL: begin
        // Landing refills the jump budget, so a press on the landing frame starts a fresh first jump
        if (touch_down || !in_air) begin
          if (jump_press) begin
            state_nxt = RISE;
            cnt_nxt   = '0;
            jumps_nxt = 2'd1;
          end else begin
            state_nxt = GROUND;
            jumps_nxt = 2'd0;
          end
        end else if (jump_press && jumps_used < JUMPS_TOP) begin
          state_nxt = RISE;
          cnt_nxt   = '0;
          jumps_nxt = jumps_used + 2'd1;
        end else begin
          fall_nxt = sat_inc_fall(fall_spd);
        end
      end
    endcase
  end

  always_comb begin
    unique case (state_nxt)
      RISE:    vy_nxt = VY_RISE;
      FALL:    vy_nxt = VEL_W'(fall_nxt);
      default: vy_nxt = '0;
    endcase
  end

  // Frame boundary: menu/pause (run_en low) behaves exactly like reset
  always_ff @(posedge frame_clk) begin
    if (Reset || !run_en) begin
      state       <= GROUND;
      cnt         <= '0;
      fall_spd    <= '0;
      jumps_used  <= 2'd0;
      timer       <= '0;
      jump_prev   <= 1'b0;
      vx          <= '0;
      vy          <= '0;
      facing_left <= 1'b0;
      charged     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      fall_spd    <= fall_nxt;
      jumps_used  <= jumps_nxt;
      timer       <= timer_nxt;
      jump_prev   <= jump_held;
      vx          <= vx_nxt;
      vy          <= vy_nxt;
      facing_left <= facing_nxt;
      charged     <= charged_nxt;
    end
  end

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Bench for ball_motion_sequencer: directed movement scenarios plus randomized play
// compared frame by frame against an integer reference model.
module tb_ball_motion_sequencer;

  localparam int P_RISE = 7, P_HANG = 5, P_JV = 8, P_FMAX = 3, P_MAXJ = 2;
  localparam int P_RUN = 1, P_CHG = 2, P_CHGF = 240;

  logic               frame_clk;
  logic               Reset, run_en;
  logic [31:0]        keycode;
  logic               in_air, touch_down, touch_up, touch_left, touch_right, charge_pulse;
  logic signed [9:0]  vx, vy;
  logic [1:0]         phase, jumps_used;
  logic               facing_left, charged;

  int checks = 0;
  int failures = 0;

  int m_phase, m_cnt, m_fall, m_jumps, m_timer, m_vx, m_vy;
  bit m_prev, m_face, m_chg;

  ball_motion_sequencer dut (
    .frame_clk(frame_clk), .Reset(Reset), .run_en(run_en), .keycode(keycode),
    .in_air(in_air), .touch_down(touch_down), .touch_up(touch_up),
    .touch_left(touch_left), .touch_right(touch_right), .charge_pulse(charge_pulse),
    .vx(vx), .vy(vy), .phase(phase), .jumps_used(jumps_used),
    .facing_left(facing_left), .charged(charged)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_key(input logic [31:0] kc, input logic [7:0] k);
    for (int i = 0; i < 4; i++) if (kc[8*i +: 8] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit r, l, jh, jp;
    int spd;
    if (Reset || !run_en) begin
      m_phase = 0; m_cnt = 0; m_fall = 0; m_jumps = 0; m_timer = 0;
      m_prev = 0; m_vx = 0; m_vy = 0; m_face = 0; m_chg = 0;
      return;
    end
    r  = has_key(keycode, 8'h07);
    l  = has_key(keycode, 8'h04);
    jh = has_key(keycode, 8'h1A);
    jp = jh && !m_prev;
    m_prev = jh;
    if (charge_pulse) m_timer = P_CHGF;
    else if (m_timer > 0) m_timer = m_timer - 1;
    m_chg = (m_timer != 0);
    spd = m_chg ? P_CHG : P_RUN;
    if (r) begin m_vx = touch_right ? 0 : spd; m_face = 0; end
    else if (l) begin m_vx = touch_left ? 0 : -spd; m_face = 1; end
    else m_vx = 0;
    case (m_phase)
      0: if (jp) begin m_phase = 1; m_cnt = 0; m_jumps = 1; end
         else if (in_air) begin m_phase = 3; m_fall = 1; m_jumps = 1; end
         else m_jumps = 0;
      1: if (touch_up) begin m_phase = 3; m_fall = 1; end
         else if (!jh || m_cnt == P_RISE - 1) begin m_phase = 2; m_cnt = 0; end
         else m_cnt = m_cnt + 1;
      2: if (m_cnt == P_HANG - 1) begin m_phase = 3; m_fall = 1; end
         else m_cnt = m_cnt + 1;
      default:
        if (touch_down || !in_air) begin
          if (jp) begin m_phase = 1; m_cnt = 0; m_jumps = 1; end
          else begin m_phase = 0; m_jumps = 0; end
        end else if (jp && m_jumps < P_MAXJ) begin
          m_phase = 1; m_cnt = 0; m_jumps = m_jumps + 1;
        end else m_fall = (m_fall < P_FMAX) ? m_fall + 1 : P_FMAX;
    endcase
    m_vy = (m_phase == 1) ? -P_JV : (m_phase == 3) ? m_fall : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    check("phase", int'(phase), m_phase);
    check("vx", int'(vx), m_vx);
    check("vy", int'(vy), m_vy);
    check("jumps_used", int'(jumps_used), m_jumps);
    check("facing_left", int'(facing_left), int'(m_face));
    check("charged", int'(charged), int'(m_chg));
  endtask

  task automatic idle();
    Reset = 0; run_en = 1; keycode = 32'h0; in_air = 0; touch_down = 0;
    touch_up = 0; touch_left = 0; touch_right = 0; charge_pulse = 0;
  endtask

  task automatic tick_until_phase(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && int'(phase) != target; i++) tick();
    check(tag, int'(phase), target);
  endtask

  int exp_vy[10] = '{-8, 0, 0, 0, 0, 0, 1, 2, 3, 3};
  int count2;
  bit jh_r, air_r;
  logic [31:0] kc;

  initial begin
    idle();
    Reset = 1;
    tick();
    check("rst_phase", int'(phase), 0);
    check("rst_vy", int'(vy), 0);
    check("rst_charged", int'(charged), 0);
    Reset = 0;
    tick();

    // Jump tap from ground
    keycode = 32'h0000_001A;
    tick();
    check("tap_vy0", int'(vy), exp_vy[0]);
    keycode = 32'h0; in_air = 1;
    for (int i = 1; i < 10; i++) begin
      tick();
      check("tap_vy", int'(vy), exp_vy[i]);
    end
    in_air = 0; touch_down = 1;
    tick();
    check("land_phase", int'(phase), 0);
    touch_down = 0;

    // Held jump, then double jump, third press ignored
    keycode = 32'h1A00_0000; in_air = 1;
    for (int i = 0; i < P_RISE; i++) begin
      tick();
      check("held_rise", int'(phase), 1);
      check("held_vy", int'(vy), -8);
    end
    tick();
    check("held_hang", int'(phase), 2);
    keycode = 32'h0;
    tick_until_phase(3, 10, "wait_fall1");
    keycode = 32'h001A_0000;
    tick();
    check("dbl_phase", int'(phase), 1);
    check("dbl_jumps", int'(jumps_used), 2);
    keycode = 32'h0;
    tick_until_phase(3, 10, "wait_fall2");
    keycode = 32'h0000_1A00;
    tick();
    check("third_phase", int'(phase), 3);
    check("third_jumps", int'(jumps_used), 2);

    // Landing and pressing on the same frame
    keycode = 32'h0;
    tick();
    keycode = 32'h0000_001A; touch_down = 1; in_air = 0;
    tick();
    check("landjump_phase", int'(phase), 1);
    check("landjump_jumps", int'(jumps_used), 1);
    touch_down = 0; in_air = 1; touch_up = 1;
    tick();
    check("ceil_phase", int'(phase), 3);
    check("ceil_vy", int'(vy), 1);
    touch_up = 0;

    // Pause while falling at terminal speed
    keycode = 32'h0000_0007; charge_pulse = 1;
    tick();
    charge_pulse = 0;
    for (int i = 0; i < 8 && int'(vy) != 3; i++) tick();
    check("fall_v3", int'(vy), 3);
    run_en = 0;
    tick();
    check("pause_phase", int'(phase), 0);
    check("pause_vx", int'(vx), 0);
    check("pause_vy", int'(vy), 0);
    check("pause_jumps", int'(jumps_used), 0);
    check("pause_charged", int'(charged), 0);

    // Charged running speed lasts exactly CHARGE_FRAMES frames
    idle();
    tick();
    keycode = 32'h0000_0007; charge_pulse = 1;
    tick();
    check("chg_vx", int'(vx), 2);
    charge_pulse = 0;
    count2 = 1;
    for (int i = 0; i < 244; i++) begin
      tick();
      if (int'(vx) == 2) count2++;
    end
    check("chg_frames", count2, P_CHGF);
    check("chg_after_vx", int'(vx), 1);
    keycode = 32'h0004_0700;
    tick();
    check("both_vx", int'(vx), 1);
    keycode = 32'h0400_0000;
    tick();
    check("left_vx", int'(vx), -1);
    check("left_face", int'(facing_left), 1);
    keycode = 32'h0;
    tick();
    check("face_hold", int'(facing_left), 1);
    keycode = 32'h0000_0007; touch_right = 1;
    tick();
    check("wall_r_vx", int'(vx), 0);
    check("wall_r_face", int'(facing_left), 0);
    touch_right = 0; keycode = 32'h0000_0004; touch_left = 1;
    tick();
    check("wall_l_vx", int'(vx), 0);
    touch_left = 0;

    // Reset in the middle of a rise
    keycode = 32'h0;
    tick();
    keycode = 32'h001A_0007; charge_pulse = 1;
    tick();
    check("mr_rise", int'(phase), 1);
    charge_pulse = 0;
    tick();
    Reset = 1;
    tick();
    check("mr_phase", int'(phase), 0);
    check("mr_vy", int'(vy), 0);
    check("mr_jumps", int'(jumps_used), 0);
    check("mr_charged", int'(charged), 0);

    // Randomized play
    idle();
    jh_r = 0; air_r = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) jh_r = !jh_r;
      if ($urandom_range(0, 7) == 0) air_r = !air_r;
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 7))
          0: kc[8*k +: 8] = 8'h07;
          1: kc[8*k +: 8] = 8'h04;
          2: kc[8*k +: 8] = 8'($urandom);
          default: kc[8*k +: 8] = 8'h00;
        endcase
      end
      if (jh_r) kc[8*$urandom_range(0, 3) +: 8] = 8'h1A;
      keycode      = kc;
      in_air       = air_r;
      touch_down   = ($urandom_range(0, 3) == 0);
      touch_up     = ($urandom_range(0, 9) == 0);
      touch_left   = ($urandom_range(0, 3) == 0);
      touch_right  = ($urandom_range(0, 3) == 0);
      charge_pulse = ($urandom_range(0, 99) == 0);
      Reset        = ($urandom_range(0, 299) == 0);
      run_en       = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
